eth_tx_frame_arbiter: RTL and testbench

- Frame-granular round-robin arbiter that shares the single user AXIS transmit input of the tri-mode Ethernet MAC between C_NUM_PORTS requesters, for example the UDP stack, ARP responder and ICMP engine.
- Sits in the tx_mac_aclk domain, directly upstream of the MAC user interface (tx_axis_mac_*).
- A grant is held from the first byte of a frame to its tlast, so frames are never interleaved.
- Also provides per-port enables and a busy/grant status.

---
 rtl/eth_tx_frame_arbiter.sv | 141 ++++++++++++++
 tb/tb_eth_tx_frame_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_frame_arbiter.sv
// Frame-granular round-robin arbiter sharing the MAC user AXIS transmit input.
// Optional per-port frame/byte statistics are built when ETH_TX_ARB_STATS_EN is defined.
module eth_tx_frame_arbiter #(
   parameter int C_NUM_PORTS = 4,
   parameter int C_IDX_W     = 2
) (
   input  logic                        tx_mac_aclk,
   input  logic                        tx_mac_reset,
   input  logic [8*C_NUM_PORTS-1:0]    s_axis_tdata,
   input  logic [C_NUM_PORTS-1:0]      s_axis_tvalid,
   input  logic [C_NUM_PORTS-1:0]      s_axis_tlast,
   output logic [C_NUM_PORTS-1:0]      s_axis_tready,
   input  logic [C_NUM_PORTS-1:0]      tx_port_en,
   output logic [7:0]                  tx_axis_mac_tdata,
   output logic                        tx_axis_mac_tvalid,
   output logic                        tx_axis_mac_tlast,
   input  logic                        tx_axis_mac_tready,
   output logic [C_NUM_PORTS-1:0]      tx_arb_grant,
   output logic                        tx_arb_busy,
   output logic [16*C_NUM_PORTS-1:0]   tx_stat_frames,
   output logic [32*C_NUM_PORTS-1:0]   tx_stat_bytes
);

   typedef enum logic {S_IDLE = 1'b0, S_XFER = 1'b1} state_t;

   state_t                 r_state, w_state_nxt;
   logic [C_NUM_PORTS-1:0] r_grant, w_grant_nxt, w_req;
   logic [C_IDX_W-1:0]     r_grant_idx, w_grant_idx_nxt;
   logic [C_IDX_W-1:0]     r_last_idx, w_last_idx_nxt, w_rr_idx;
   logic                   r_busy, w_busy_nxt, w_rr_found;
   logic                   w_xfer, w_mac_tvalid, w_mac_tlast, w_eof;
   logic [7:0]             w_mac_tdata;
   logic [7:0]             w_port_data [C_NUM_PORTS];

   assign w_req = s_axis_tvalid & tx_port_en;

   // Cyclic search starting just after the last served port.
   always_comb begin : rr_search
      int w_j;
      w_rr_idx   = '0;
      w_rr_found = 1'b0;
      w_j        = 0;
      for (int k = 1; k <= C_NUM_PORTS; k++) begin
         w_j = int'(r_last_idx) + k;
         if (w_j >= C_NUM_PORTS) w_j = w_j - C_NUM_PORTS;
         if (!w_rr_found && w_req[C_IDX_W'(w_j)]) begin
            w_rr_found = 1'b1;
            w_rr_idx   = C_IDX_W'(w_j);
         end
      end
   end

   always_comb begin
      for (int i = 0; i < C_NUM_PORTS; i++) w_port_data[i] = s_axis_tdata[8*i +: 8];
   end

   assign w_xfer        = (r_state == S_XFER);
   assign w_mac_tvalid  = w_xfer & s_axis_tvalid[r_grant_idx];
   assign w_mac_tlast   = w_xfer & s_axis_tlast[r_grant_idx];
   assign w_mac_tdata   = w_xfer ? w_port_data[r_grant_idx] : 8'h00;
   assign w_eof         = w_mac_tvalid & tx_axis_mac_tready & w_mac_tlast;

   // r_grant is all-zero outside XFER, so only the granted port ever sees ready.
   assign s_axis_tready      = r_grant & {C_NUM_PORTS{tx_axis_mac_tready}};
   assign tx_axis_mac_tdata  = w_mac_tdata;
   assign tx_axis_mac_tvalid = w_mac_tvalid;
   assign tx_axis_mac_tlast  = w_mac_tlast;
   assign tx_arb_grant       = r_grant;
   assign tx_arb_busy        = r_busy;

   always_comb begin
      w_state_nxt     = r_state;
      w_grant_nxt     = r_grant;
      w_grant_idx_nxt = r_grant_idx;
      w_last_idx_nxt  = r_last_idx;
      w_busy_nxt      = r_busy;
      case (r_state)
         S_IDLE: begin
            if (w_rr_found) begin
               w_state_nxt     = S_XFER;
               w_grant_nxt     = {{(C_NUM_PORTS-1){1'b0}}, 1'b1} << w_rr_idx;
               w_grant_idx_nxt = w_rr_idx;
               w_busy_nxt      = 1'b1;
            end
         end
         S_XFER: begin
            if (w_eof) begin
               w_state_nxt    = S_IDLE;
               w_grant_nxt    = '0;
               w_busy_nxt     = 1'b0;
               w_last_idx_nxt = r_grant_idx;
            end
         end
      endcase
   end

   always_ff @(posedge tx_mac_aclk or posedge tx_mac_reset) begin
      if (tx_mac_reset) begin
         r_state     <= S_IDLE;
         r_grant     <= '0;
         r_grant_idx <= '0;
         r_last_idx  <= C_IDX_W'(C_NUM_PORTS-1);
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_grant     <= w_grant_nxt;
         r_grant_idx <= w_grant_idx_nxt;
         r_last_idx  <= w_last_idx_nxt;
         r_busy      <= w_busy_nxt;
      end
   end

`ifdef ETH_TX_ARB_STATS_EN
   logic [15:0] r_stat_frames [C_NUM_PORTS];
   logic [31:0] r_stat_bytes  [C_NUM_PORTS];
   logic        w_beat;

   assign w_beat = w_mac_tvalid & tx_axis_mac_tready;

   always_ff @(posedge tx_mac_aclk or posedge tx_mac_reset) begin
      if (tx_mac_reset) begin
         for (int i = 0; i < C_NUM_PORTS; i++) begin
            r_stat_frames[i] <= '0;
            r_stat_bytes[i]  <= '0;
         end
      end else if (w_beat) begin
         r_stat_bytes[r_grant_idx] <= r_stat_bytes[r_grant_idx] + 32'd1;
         if (w_mac_tlast) r_stat_frames[r_grant_idx] <= r_stat_frames[r_grant_idx] + 16'd1;
      end
   end

   for (genvar g = 0; g < C_NUM_PORTS; g++) begin : g_stat
      assign tx_stat_frames[16*g +: 16] = r_stat_frames[g];
      assign tx_stat_bytes[32*g +: 32]  = r_stat_bytes[g];
   end
`else
   assign tx_stat_frames = '0;
   assign tx_stat_bytes  = '0;
`endif

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Scoreboard bench for eth_tx_frame_arbiter: per-port source queues feed the DUT,
// expected MAC beats (with the port that must be granted) are queued at load time.
module tb_eth_tx_frame_arbiter;
   localparam int N = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic [8*N-1:0]   s_axis_tdata;
   logic [N-1:0]     s_axis_tvalid, s_axis_tlast, s_axis_tready, tx_port_en;
   logic [7:0]       tx_axis_mac_tdata;
   logic             tx_axis_mac_tvalid, tx_axis_mac_tlast, tx_axis_mac_tready;
   logic [N-1:0]     tx_arb_grant;
   logic             tx_arb_busy;
   logic [16*N-1:0]  tx_stat_frames;
   logic [32*N-1:0]  tx_stat_bytes;

   eth_tx_frame_arbiter #(.C_NUM_PORTS(N), .C_IDX_W(2)) dut (
      .tx_mac_aclk        (clk),
      .tx_mac_reset       (rst),
      .s_axis_tdata       (s_axis_tdata),
      .s_axis_tvalid      (s_axis_tvalid),
      .s_axis_tlast       (s_axis_tlast),
      .s_axis_tready      (s_axis_tready),
      .tx_port_en         (tx_port_en),
      .tx_axis_mac_tdata  (tx_axis_mac_tdata),
      .tx_axis_mac_tvalid (tx_axis_mac_tvalid),
      .tx_axis_mac_tlast  (tx_axis_mac_tlast),
      .tx_axis_mac_tready (tx_axis_mac_tready),
      .tx_arb_grant       (tx_arb_grant),
      .tx_arb_busy        (tx_arb_busy),
      .tx_stat_frames     (tx_stat_frames),
      .tx_stat_bytes      (tx_stat_bytes)
   );

   always #4 clk = ~clk;

   int          n_cmp = 0;
   int          n_err = 0;
   int          n_beats = 0;
   int          idle_run = 0;
   bit          in_frame = 1'b0;
   bit          have_prev = 1'b0;
   bit          chk_gap = 1'b0;
   logic [8:0]  src_q [N][$];
   logic [10:0] exp_q [$];

   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic load_frame(input int port, input int len, input logic [7:0] base, input bit push_exp);
      logic [8:0] b;
      logic [1:0] p;
      p = port[1:0];
      for (int k = 0; k < len; k++) begin
         b = {(k == len - 1), base + 8'(k)};
         src_q[port].push_back(b);
         if (push_exp) exp_q.push_back({p, b});
      end
   endtask

   task automatic drive();
      logic [8:0] h;
      for (int i = 0; i < N; i++) begin
         if (src_q[i].size() > 0) begin
            h = src_q[i][0];
            s_axis_tvalid[i]       = 1'b1;
            s_axis_tdata[8*i +: 8] = h[7:0];
            s_axis_tlast[i]        = h[8];
         end else begin
            s_axis_tvalid[i]       = 1'b0;
            s_axis_tdata[8*i +: 8] = 8'h00;
            s_axis_tlast[i]        = 1'b0;
         end
      end
   endtask

   task automatic step();
      logic [N-1:0] acc;
      logic [10:0]  e;
      @(negedge clk);
      if (tx_axis_mac_tvalid && tx_axis_mac_tready) begin
         n_beats++;
         if (exp_q.size() == 0) begin
            chk("extra_beat", {tx_axis_mac_tlast, tx_axis_mac_tdata}, 9'h1ff);
         end else begin
            e = exp_q.pop_front();
            chk("beat", {tx_axis_mac_tlast, tx_axis_mac_tdata}, e[8:0]);
            chk("beat_grant", tx_arb_grant, 4'b0001 << e[10:9]);
         end
         if (!in_frame && chk_gap && have_prev) chk("ifg", idle_run, 1);
         in_frame = !tx_axis_mac_tlast;
         if (tx_axis_mac_tlast) begin
            have_prev = 1'b1;
            idle_run  = 0;
         end
      end else begin
         idle_run++;
      end
      chk("rdy_iso", s_axis_tready & ~tx_arb_grant, 0);
      acc = s_axis_tvalid & s_axis_tready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      drive();
   endtask

   task automatic run_until_done(input int max_cyc, input string tag);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < max_cyc) begin
         step();
         n++;
      end
      chk(tag, exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic wait_beats(input int nb);
      int n0, g;
      n0 = n_beats;
      g  = 0;
      while (n_beats - n0 < nb && g < 200) begin
         step();
         g++;
      end
      chk("wait_beats", n_beats - n0, nb);
   endtask

   task automatic clear_all();
      for (int i = 0; i < N; i++) src_q[i].delete();
      exp_q.delete();
      in_frame = 1'b0;
      drive();
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      clear_all();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst                = 1'b1;
      tx_port_en         = '1;
      tx_axis_mac_tready = 1'b1;
      s_axis_tvalid      = '1;
      s_axis_tlast       = '1;
      s_axis_tdata       = 32'hA5A5_A5A5;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_grant", tx_arb_grant, 0);
      chk("rst_busy", tx_arb_busy, 0);
      chk("rst_s_tready", s_axis_tready, 0);
      chk("rst_mac_tvalid", tx_axis_mac_tvalid, 0);
      chk("rst_mac_tlast", tx_axis_mac_tlast, 0);
      chk("rst_mac_tdata", tx_axis_mac_tdata, 0);
      clear_all();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // All ports requesting: order 0,1,2,3,0 with one idle cycle between frames
      chk_gap   = 1'b1;
      have_prev = 1'b0;
      load_frame(0, 10, 8'h20, 1'b1);
      load_frame(1, 10, 8'h40, 1'b1);
      load_frame(2, 10, 8'h60, 1'b1);
      load_frame(3, 10, 8'h80, 1'b1);
      load_frame(0, 10, 8'hA0, 1'b1);
      drive();
      run_until_done(300, "rr_done");
      chk_gap = 1'b0;

      // Port 2 alone, 60 bytes
      load_frame(2, 60, 8'h10, 1'b1);
      drive();
      chk("p2_idle_grant", tx_arb_grant, 0);
      chk("p2_idle_tvalid", tx_axis_mac_tvalid, 0);
      step();
      chk("p2_grant", tx_arb_grant, 4'b0100);
      chk("p2_busy", tx_arb_busy, 1);
      run_until_done(200, "p2_done");
      chk("p2_busy_end", tx_arb_busy, 0);
      chk("p2_grant_end", tx_arb_grant, 0);

      // MAC backpressure for 12 cycles mid-frame on port 1
      load_frame(1, 20, 8'hC0, 1'b1);
      drive();
      wait_beats(5);
      tx_axis_mac_tready = 1'b0;
      repeat (12) begin
         step();
         chk("bp_rdy1", s_axis_tready[1], 0);
         chk("bp_tvalid", tx_axis_mac_tvalid, 1);
         chk("bp_tdata", tx_axis_mac_tdata, 8'hC5);
      end
      tx_axis_mac_tready = 1'b1;
      run_until_done(100, "bp_done");

      // Port enables: port 1 disabled, port 3 enable dropped mid-frame
      tx_port_en = 4'b1101;
      load_frame(1, 6, 8'h50, 1'b0);
      load_frame(3, 8, 8'h30, 1'b1);
      drive();
      wait_beats(3);
      tx_port_en[3] = 1'b0;
      run_until_done(100, "en_done");
      repeat (4) step();
      chk("en_no_grant", tx_arb_grant, 0);
      chk("en_busy", tx_arb_busy, 0);
      chk("en_rdy1", s_axis_tready[1], 0);
      src_q[1].delete();
      tx_port_en = '1;
      drive();

      // Asynchronous reset mid-frame restores round-robin pointer
      load_frame(1, 12, 8'h70, 1'b1);
      drive();
      run_until_done(100, "pre_rst_done");
      load_frame(0, 20, 8'h90, 1'b1);
      drive();
      wait_beats(5);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_grant", tx_arb_grant, 0);
      chk("arst_tvalid", tx_axis_mac_tvalid, 0);
      chk("arst_busy", tx_arb_busy, 0);
      chk("arst_s_tready", s_axis_tready, 0);
      clear_all();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      load_frame(0, 5, 8'h11, 1'b1);
      load_frame(2, 5, 8'hE0, 1'b1);
      drive();
      run_until_done(100, "post_rst_done");

`ifdef ETH_TX_ARB_STATS_EN
      pulse_reset();
      load_frame(3, 64, 8'h00, 1'b1);
      load_frame(3, 100, 8'h40, 1'b1);
      load_frame(3, 1, 8'hEE, 1'b1);
      drive();
      run_until_done(600, "stat_done");
      chk("stat_frames_p3", tx_stat_frames[48 +: 16], 3);
      chk("stat_bytes_p3", tx_stat_bytes[96 +: 32], 165);
      for (int i = 0; i < 3; i++) begin
         chk("stat_frames_other", tx_stat_frames[16*i +: 16], 0);
         chk("stat_bytes_other", tx_stat_bytes[32*i +: 32], 0);
      end
`else
      chk("stat_frames_tied", tx_stat_frames, 0);
      chk("stat_bytes_tied", tx_stat_bytes, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
